// File: rtl/f_fetch_ctrl_if.sv
// Fetch-stage bundle: NPC/hazard/CP0 controls, instruction-memory handshake,
// and the F-stage result handed to the F/D pipeline register.
interface f_fetch_ctrl_if;
  logic [31:0] npc;
  logic        d_stall;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        f_exc_adel;

  modport master (
    input  npc, d_stall, exc_req, eret_req, epc, imem_ready, imem_rdata,
    output imem_req, imem_addr, f_pc, f_instr, f_valid, f_exc_adel
  );

  modport slave (
    output npc, d_stall, exc_req, eret_req, epc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, f_pc, f_instr, f_valid, f_exc_adel
  );
endinterface

// File: rtl/f_fetch_ctrl.sv
// F-stage sequencer: owns the PC, issues instruction-memory requests, holds the
// fetched word under D stalls and drains in-flight fetches after a redirect.
module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI   = 32'h0000_6FFC
) (
  input  logic            clk,
  input  logic            reset,
  f_fetch_ctrl_if.master  fb
);

  typedef enum logic [1:0] {FETCH, VALID, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic        adel_q, adel_d;
  logic [31:0] drop_q, drop_d;

  logic        redirect, bad, complete;
  logic [31:0] target;
  logic        req, fv, fa;
  logic [31:0] addr, fi;

  assign redirect = fb.exc_req | fb.eret_req;
  assign target   = fb.exc_req ? EXC_ENTRY : fb.epc;
  assign bad      = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ibuf_q  <= '0;
      adel_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
      adel_q  <= adel_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ibuf_d   = ibuf_q;
    adel_d   = adel_q;
    drop_d   = drop_q;
    req      = 1'b0;
    addr     = '0;
    fv       = 1'b0;
    fi       = '0;
    fa       = 1'b0;
    complete = 1'b0;

    case (state_q)
      FETCH: begin
        // An illegal PC never reaches memory; it completes at once as a nop.
        if (bad) begin
          fv       = 1'b1;
          fa       = 1'b1;
          complete = 1'b1;
        end else begin
          req      = 1'b1;
          addr     = pc_q;
          fv       = fb.imem_ready;
          fi       = fb.imem_rdata;
          complete = fb.imem_ready;
        end
        if (redirect && !complete) begin
          drop_d  = pc_q;
          pc_d    = target;
          state_d = DROP;
        end else if (redirect) begin
          pc_d = target;
        end else if (fv && !fb.d_stall) begin
          pc_d = fb.npc;
        end else if (complete) begin
          ibuf_d  = fi;
          adel_d  = bad;
          state_d = VALID;
        end
      end
      VALID: begin
        fv = 1'b1;
        fi = ibuf_q;
        fa = adel_q;
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!fb.d_stall) begin
          pc_d    = fb.npc;
          state_d = FETCH;
        end
      end
      DROP: begin
        // Keep the abandoned request on the bus until memory retires it.
        req  = 1'b1;
        addr = drop_q;
        if (redirect) pc_d = target;
        if (fb.imem_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (reset) begin
      req  = 1'b0;
      addr = '0;
      fv   = 1'b0;
      fi   = '0;
      fa   = 1'b0;
    end
  end

  assign fb.imem_req   = req;
  assign fb.imem_addr  = addr;
  assign fb.f_valid    = fv;
  assign fb.f_instr    = fi;
  assign fb.f_exc_adel = fa;
  assign fb.f_pc       = reset ? RESET_PC : pc_q;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Directed bench for f_fetch_ctrl: a latency-programmable memory model, a
// scoreboard of instructions D should capture, and cycle-level direct checks.
module tb_f_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  logic clk;
  logic reset;
  f_fetch_ctrl_if bus();

  f_fetch_ctrl dut (.clk(clk), .reset(reset), .fb(bus.master));

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   lat;
  int   wcnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ready in the lat-th consecutive request cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign bus.imem_ready = bus.imem_req && (wcnt >= lat - 1);
  assign bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  // Scoreboard monitor: one pop per instruction D captures.
  always @(negedge clk) begin
    if (!reset && bus.f_valid && !bus.d_stall) begin
      exp_t got, e;
      got = '{bus.f_pc, bus.f_instr, bus.f_exc_adel};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL capture: unexpected pc=%h instr=%h adel=%b", got.pc, got.instr, got.adel);
      end else begin
        e = sb_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL capture: got pc=%h instr=%h adel=%b expected pc=%h instr=%h adel=%b",
                   got.pc, got.instr, got.adel, e.pc, e.instr, e.adel);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic adel);
    sb_q.push_back('{pc, instr, adel});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, bus.imem_req},   32'd0);
    chk({tag, "_addr"},  bus.imem_addr,           32'd0);
    chk({tag, "_valid"}, {31'd0, bus.f_valid},    32'd0);
    chk({tag, "_adel"},  {31'd0, bus.f_exc_adel}, 32'd0);
    chk({tag, "_instr"}, bus.f_instr,             32'd0);
    chk({tag, "_pc"},    bus.f_pc,                32'h3000);
  endtask

  // Assert reset now, hold it across an edge, release after the next edge.
  task automatic do_reset();
    reset = 1'b1;
    bus.d_stall = 1'b1;
    bus.exc_req = 1'b0;
    bus.eret_req = 1'b0;
    next_cyc();
    #2;
    chk_reset_outputs("rst");
    next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    lat = 1;
    bus.npc = 32'h3004;
    bus.d_stall = 1'b1;
    bus.exc_req = 1'b0;
    bus.eret_req = 1'b0;
    bus.epc = 32'h0;
    #1;

    // 1: zero-wait memory, sequential npc, one instruction per cycle
    push(32'h3000, mem_word(32'h3000), 1'b0);
    push(32'h3004, mem_word(32'h3004), 1'b0);
    push(32'h3008, mem_word(32'h3008), 1'b0);
    do_reset();
    lat = 1; bus.d_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.npc = 32'h3004 + 32'(i) * 4;
      #2;
      chk("seq_pc", bus.f_pc, 32'h3000 + 32'(i) * 4);
      chk("seq_valid", {31'd0, bus.f_valid}, 32'd1);
      next_cyc();
    end
    bus.d_stall = 1'b1;

    // 2: 3-cycle memory with a 2-cycle stall on arrival
    push(32'h3000, mem_word(32'h3000), 1'b0);
    do_reset();
    lat = 3; bus.d_stall = 1'b0; bus.npc = 32'h3100;
    #2;
    chk("lat3_c1_valid", {31'd0, bus.f_valid}, 32'd0);
    chk("lat3_c1_addr", bus.imem_addr, 32'h3000);
    next_cyc(); #2;
    chk("lat3_c2_valid", {31'd0, bus.f_valid}, 32'd0);
    next_cyc(); bus.d_stall = 1'b1; #2;
    chk("lat3_c3_valid", {31'd0, bus.f_valid}, 32'd1);
    chk("lat3_c3_instr", bus.f_instr, mem_word(32'h3000));
    next_cyc(); #2;
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_instr", bus.f_instr, mem_word(32'h3000));
    next_cyc(); bus.d_stall = 1'b0; #2;
    chk("hold2_instr", bus.f_instr, mem_word(32'h3000));
    next_cyc(); bus.d_stall = 1'b1; #2;
    chk("resume_addr", bus.imem_addr, 32'h3100);

    // 3: exception during a 3-cycle fetch at 0x3010, then reset mid-request
    push(32'h3000, mem_word(32'h3000), 1'b0);
    do_reset();
    lat = 1; bus.d_stall = 1'b0; bus.npc = 32'h3010;
    next_cyc(); lat = 3; #2;
    chk("drop_c2_addr", bus.imem_addr, 32'h3010);
    next_cyc(); bus.exc_req = 1'b1; #2;
    chk("drop_c3_addr", bus.imem_addr, 32'h3010);
    chk("drop_c3_valid", {31'd0, bus.f_valid}, 32'd0);
    next_cyc(); bus.exc_req = 1'b0; #2;
    chk("drop_c4_addr", bus.imem_addr, 32'h3010);
    chk("drop_c4_valid", {31'd0, bus.f_valid}, 32'd0);
    chk("drop_c4_ready", {31'd0, bus.imem_ready}, 32'd1);
    chk("drop_c4_pc", bus.f_pc, 32'h4180);
    next_cyc(); bus.d_stall = 1'b1; #2;
    chk("exc_addr", bus.imem_addr, 32'h4180);
    chk("exc_req_out", {31'd0, bus.imem_req}, 32'd1);
    next_cyc(); reset = 1'b1; #2;
    chk_reset_outputs("midrst");

    // 4/5: exc+eret together, then eret to a misaligned epc, then npc past HI
    do_reset();
    lat = 1; bus.d_stall = 1'b1;
    bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h3040;
    next_cyc();
    bus.exc_req = 1'b0; bus.eret_req = 1'b1; bus.epc = 32'h3042; #2;
    chk("exc_wins_pc", bus.f_pc, 32'h4180);
    next_cyc(); bus.eret_req = 1'b0; #2;
    chk("eret_pc", bus.f_pc, 32'h3042);
    chk("eret_req_out", {31'd0, bus.imem_req}, 32'd0);
    chk("eret_addr", bus.imem_addr, 32'd0);
    chk("eret_valid", {31'd0, bus.f_valid}, 32'd1);
    chk("eret_adel", {31'd0, bus.f_exc_adel}, 32'd1);
    chk("eret_instr", bus.f_instr, 32'd0);
    push(32'h3042, 32'd0, 1'b1);
    next_cyc(); bus.d_stall = 1'b0; bus.npc = 32'h7000; #2;
    chk("vbuf_adel", {31'd0, bus.f_exc_adel}, 32'd1);
    chk("vbuf_req", {31'd0, bus.imem_req}, 32'd0);
    next_cyc(); bus.d_stall = 1'b1; #2;
    chk("hi_pc", bus.f_pc, 32'h7000);
    chk("hi_adel", {31'd0, bus.f_exc_adel}, 32'd1);
    chk("hi_req", {31'd0, bus.imem_req}, 32'd0);

    // 6: boundaries: 0x6FFC legal, 0x2FFC and wrapped 0 illegal
    push(32'h3000, mem_word(32'h3000), 1'b0);
    push(32'h6FFC, mem_word(32'h6FFC), 1'b0);
    push(32'h2FFC, 32'd0, 1'b1);
    push(32'h0000, 32'd0, 1'b1);
    do_reset();
    lat = 1; bus.d_stall = 1'b0; bus.npc = 32'h6FFC;
    next_cyc(); bus.npc = 32'h2FFC; #2;
    chk("hi_edge_req", {31'd0, bus.imem_req}, 32'd1);
    next_cyc(); bus.npc = 32'h0000; #2;
    chk("lo_edge_req", {31'd0, bus.imem_req}, 32'd0);
    chk("lo_edge_adel", {31'd0, bus.f_exc_adel}, 32'd1);
    next_cyc(); bus.npc = 32'h3000; #2;
    chk("wrap_pc", bus.f_pc, 32'h0);
    chk("wrap_adel", {31'd0, bus.f_exc_adel}, 32'd1);
    next_cyc(); bus.d_stall = 1'b1;
    next_cyc(); #2;

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
